// File: rtl/sum_accumulator.sv
// Accumulates COUNT consecutive WIDTH-bit sums into an ACC_W-bit total with a sticky carry flag.
// The total is presented on a registered valid/ready port and held until it is taken.
module sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   sum_ext;

  // One extra bit captures the carry out of the truncated accumulator.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - WIDTH){1'b0}}, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (state == ACCUM) begin
      if (in_valid) begin
        acc_nxt = sum_ext[ACC_W-1:0];
        ovf_nxt = ovf | sum_ext[ACC_W];
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    end else if (out_ready) begin
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      state_nxt = ACCUM;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives a 40-bit and a 33-bit accumulator with shared stimulus and checks both against a block-sum model.
module tb_sum_accumulator;

  localparam int COUNT = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [31:0] in_data;
  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [39:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [32:0] b_out_data;

  int total = 0;
  int bad   = 0;

  sum_accumulator #(.WIDTH(32), .COUNT(COUNT), .ACC_W(40)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  sum_accumulator #(.WIDTH(32), .COUNT(COUNT), .ACC_W(33)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: exact (untruncated) sum of the current block, accepted count, and whether a total is pending.
  longint unsigned m_sum;
  int              m_n;
  bit              m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_sum = 0; m_n = 0; m_hold = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_sum  = 0;
      end
    end else if (in_valid) begin
      m_sum += longint'(in_data);
      m_n++;
      if (m_n == COUNT) begin
        m_hold = 1;
        m_n    = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready",  64'(a_in_ready),  64'(!m_hold));
    chk("a_out_valid", 64'(a_out_valid), 64'(m_hold));
    chk("a_out_data",  64'(a_out_data),  m_sum % (64'd1 << 40));
    chk("a_out_ovf",   64'(a_out_ovf),   64'(m_sum >= (64'd1 << 40)));
    chk("b_in_ready",  64'(b_in_ready),  64'(!m_hold));
    chk("b_out_valid", 64'(b_out_valid), 64'(m_hold));
    chk("b_out_data",  64'(b_out_data),  m_sum % (64'd1 << 33));
    chk("b_out_ovf",   64'(b_out_ovf),   64'(m_sum >= (64'd1 << 33)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #3;
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_out_ovf",   64'(a_out_ovf),   64'd0);
    #9 rst_n = 1'b1;
    tick();

    // Basic block
    send(7); send(25); send(350); send(35674);
    chk("basic_valid", 64'(a_out_valid), 64'd1);
    chk("basic_data",  64'(a_out_data),  64'd36056);
    chk("basic_ovf",   64'(a_out_ovf),   64'd0);
    chk("basic_ready", 64'(a_in_ready),  64'd0);
    idle(1);
    chk("basic_valid_drop", 64'(a_out_valid), 64'd0);
    chk("basic_ready_back", 64'(a_in_ready),  64'd1);

    // Back-pressure with an input offered during HOLD
    out_ready = 1'b0;
    send(7); send(25); send(350); send(35674);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data",  64'(a_out_data),  64'd36056);
      chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
      in_valid = 1'b1;
      in_data  = 32'd999;
      tick();
    end
    chk("bp_hold_data6", 64'(a_out_data), 64'd36056);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_next_acc0", 64'(a_out_data), 64'd0);
    send(1); send(2); send(3); send(4);
    chk("bp_next_data", 64'(a_out_data), 64'd10);
    idle(1);

    // Overflow in the 33-bit accumulator
    repeat (4) send(32'hFFFF_FFFF);
    chk("ovf33_data", 64'(b_out_data), 64'h1_FFFF_FFFC);
    chk("ovf33_flag", 64'(b_out_ovf),  64'd1);
    chk("ovf40_data", 64'(a_out_data), 64'h3_FFFF_FFFC);
    chk("ovf40_flag", 64'(a_out_ovf),  64'd0);
    idle(1);
    repeat (4) send(32'd1);
    chk("ovf33_next_data", 64'(b_out_data), 64'd4);
    chk("ovf33_next_flag", 64'(b_out_ovf),  64'd0);
    idle(1);

    // Gapped input
    send(3); idle(2); send(4); idle(2); send(10); idle(2);
    chk("gap_not_yet", 64'(a_out_valid), 64'd0);
    send(15);
    chk("gap_valid", 64'(a_out_valid), 64'd1);
    chk("gap_data",  64'(a_out_data),  64'd32);
    idle(1);

    // Clear mid-block
    send(100); send(200);
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("clr_acc0", 64'(a_out_data), 64'd0);
    send(1); send(2); send(3); send(4);
    chk("clr_data", 64'(a_out_data), 64'd10);
    idle(1);

    // Clear during HOLD
    out_ready = 1'b0;
    repeat (4) send(32'd5);
    chk("clrh_valid", 64'(a_out_valid), 64'd1);
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("clrh_valid_drop", 64'(a_out_valid), 64'd0);
    chk("clrh_data",       64'(a_out_data),  64'd0);

    // Async reset in HOLD
    repeat (4) send(32'd1);
    chk("arst_pre_valid", 64'(a_out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_out_valid), 64'd0);
    chk("arst_ready", 64'(a_in_ready),  64'd1);
    chk("arst_data",  64'(a_out_data),  64'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) send(32'd1);
    chk("arst_after_data", 64'(a_out_data), 64'd4);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      out_ready = ($urandom_range(0, 1) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the `n_bit_adder` result. It accepts a stream of WIDTH-bit sums over a valid/ready handshake and accumulates COUNT consecutive sums into a wider register. It then presents the block total, with a sticky overflow flag, on a valid/ready output port. It sits between the combinational adder and any block-level consumer, such as a checksum or averaging stage.

## Interface
- WIDTH, 32, width of each incoming sum; matches the adder output `y`.
- COUNT, 4, number of sums per block; legal range 1..255.
- ACC_W, 40, accumulator and output width; must be ≥ WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort; drops the current block.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  sum from the adder; zero-extended to ACC_W.
- out_valid  output  1  out_data and out_ovf hold a completed block total.
- out_ready  input  1  downstream accepts the output.
- out_data  output  ACC_W  block total, modulo 2^ACC_W.
- out_ovf  output  1  a carry out of bit ACC_W-1 occurred during this block.

## Operation
- State machine has two states.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Registers:
  - acc[ACC_W-1:0]
  - cnt[7:0]
  - ovf (sticky)
  - state
- Input accept: in_valid && in_ready at a rising edge.
  - acc ← acc + zext(in_data), truncated to ACC_W.
  - ovf ← ovf | carry out of that add.
  - cnt ← cnt+1.
- Accept with cnt == COUNT-1:
  - Go to HOLD on that edge.
  - acc and ovf take the final values.
  - cnt ← 0.
- out_data = acc and out_ovf = ovf. Both are registered and stable throughout HOLD.
- HOLD exits only on out_valid && out_ready. On that edge:
  - acc ← 0, ovf ← 0.
  - Go to ACCUM.
- clear=1 at an edge, from any state:
  - acc ← 0, cnt ← 0, ovf ← 0, state ← ACCUM.
  - A pending output is discarded.
  - clear overrides a simultaneous input accept and a simultaneous output handshake.
- COUNT=1: every accepted sum moves straight to HOLD.
- in_valid while in HOLD: not accepted. The upstream holds in_data until in_ready returns.
- No combinational path from any input to any output. in_ready and out_valid decode state only.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- Reset release: the first accept can happen at the first rising edge with rst_n=1.
- Reset asserted mid-block or in HOLD: everything returns to reset values immediately. The partial block is lost.
- Latency: out_valid rises on the same edge that accepts the COUNT-th sum. It is visible in the following cycle.
- Throughput:
  - One sum per cycle inside a block.
  - At least one HOLD cycle per block.
  - in_ready returns the cycle after the output handshake.
  - Best case is COUNT+1 cycles per block.
- Output back-pressure: with out_ready=0, HOLD lasts indefinitely. out_data and out_ovf must not change.
- in_valid may toggle freely. Gaps between accepts do not affect the result.

## Test plan
- Basic block, COUNT=4, out_ready=1:
  - Stimulus: in_data 7, 25, 350, 35674 on consecutive cycles.
  - Required: out_valid=1 for one cycle with out_data=36056, out_ovf=0.
  - Required: in_ready=0 during that cycle.
- Back-pressure:
  - Stimulus: same four sums with out_ready=0 for 5 cycles, then 1.
  - Required: out_data=36056 is held for 6 cycles.
  - Required: the extra in_valid offered during HOLD is not accepted.
  - Required: the next block starts from acc=0.
- Overflow, ACC_W=33, COUNT=4:
  - Stimulus: four inputs of 0xFFFFFFFF.
  - Required: out_data=0x1FFFFFFFC, out_ovf=1.
  - Required: the following block of four 1s gives out_data=4, out_ovf=0.
- Gapped input:
  - Stimulus: sums 3, 4, 10, 15 with in_valid low for 2 cycles between each.
  - Required: out_data=32, and it appears only after the 4th accept.
- clear:
  - Stimulus: assert clear after 2 of 4 sums (values 100 and 200), then send 1, 2, 3, 4.
  - Required: out_data=10.
  - Stimulus: assert clear during HOLD.
  - Required: out_valid drops on the next edge.
- Async reset:
  - Stimulus: pull rst_n low mid-cycle while in HOLD.
  - Required: out_valid=0 and in_ready=1 immediately, before the next clock edge.
  - Required: after release, sums 1, 1, 1, 1 give out_data=4.
